// File: rtl/kss_cpu_pkg.sv
// Shared definitions for the basic-computer execution core: opcodes,
// controller states and instruction field positions.
package kss_cpu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_DONE
  } state_e;

  localparam int OP_LSB   = 6;
  localparam int DEST_LSB = 4;
  localparam int SRCA_LSB = 2;
  localparam int SRCB_LSB = 0;

  function automatic logic [1:0] ir_field(input logic [7:0] ir, input int lsb);
    return ir[lsb +: 2];
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Instruction-memory and write-back bus of exec_ctrl; master is the controller,
// slave is the instruction memory / write-back observer.
interface exec_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 1
);
  logic [PC_W-1:0]   pc;
  logic [7:0]        inst;
  logic              wb_en;
  logic [1:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (output pc, input inst, output wb_en, output wb_addr, output wb_data);
  modport slave  (input pc, output inst, input wb_en, input wb_addr, input wb_data);
endinterface

// File: rtl/exec_ctrl_reg_file4.sv
// 4-entry register file: one synchronous write port, two operand read ports
// and one debug read port, all reads combinational.
module reg_file4 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        ra_addr,
  input  logic [1:0]        rb_addr,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/exec_ctrl.sv
// Fetch/decode/execute/write-back controller for the basic computer; runs
// PROG_LEN instructions from inst_mem against a 4-entry register file.
module exec_ctrl
  import kss_cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PC_W     = 1,
  parameter int PROG_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_en,
  input  logic [1:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [1:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  exec_ctrl_if.master       bus
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic              wb_en_q, wb_en_d;
  logic [1:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic [DATA_W-1:0] alu_res, ra_data, rb_data;
  logic [1:0]        dest;
  logic              pc_last;
  logic              rf_we;
  logic [1:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign dest    = ir_field(ir_q, DEST_LSB);
  assign pc_last = (pc_q == PC_LAST);

  // Preloads and write-backs never collide: one is IDLE-only, the other WB-only.
  assign rf_we    = (state_q == S_IDLE && ld_en) || (state_q == S_WB);
  assign rf_waddr = (state_q == S_WB) ? dest  : ld_addr;
  assign rf_wdata = (state_q == S_WB) ? res_q : ld_data;

  reg_file4 #(.DATA_W(DATA_W)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_addr  (ir_field(ir_q, SRCA_LSB)),
    .rb_addr  (ir_field(ir_q, SRCB_LSB)),
    .dbg_addr (rd_addr),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = pc_last ? S_DONE : S_FETCH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_FETCH) || (state_q == S_DECODE) ||
           (state_q == S_EXEC)  || (state_q == S_WB);
    done = (state_q == S_DONE);
  end

  always_comb begin
    alu_res = '0;
    case (ir_field(ir_q, OP_LSB))
      OP_AND:  alu_res = opa_q & opb_q;
      OP_OR:   alu_res = opa_q | opb_q;
      OP_XOR:  alu_res = opa_q ^ opb_q;
      OP_ADD:  alu_res = opa_q + opb_q;
      default: alu_res = '0;
    endcase
  end

  // wb_* are loaded on the EXEC edge so the strobe coincides with the WB state.
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_FETCH:  ir_d = bus.inst;
      S_DECODE: begin
        opa_d = ra_data;
        opb_d = rb_data;
      end
      S_EXEC: begin
        res_d     = alu_res;
        wb_en_d   = 1'b1;
        wb_addr_d = dest;
        wb_data_d = alu_res;
      end
      S_WB:     pc_d = pc_last ? '0 : pc_q + PC_W'(1);
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      ir_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.wb_en   = wb_en_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Multi-cycle fetch/decode/execute controller downstream of `inst_mem`. It drives the program counter into `inst_mem`, latches the returned 8-bit instruction, decodes it, and executes it against a 4-entry register file with a small ALU. When `PROG_LEN` instructions have been written back, it reports completion. It is the execution core of the basic-computer example, and the register file is preloadable and readable from the bench.

## Interface
Parameters:
- `DATA_W`, 8: register and ALU width
- `PC_W`, 1: program counter width, matching the `inst_mem` address
- `PROG_LEN`, 2: number of instructions executed per run, from 1 to 2**PC_W

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge
- `rst`, in, 1: synchronous, active-high reset
- `start`, in, 1: begins a run; sampled only in IDLE
- `pc`, out, PC_W: instruction address, driven to `inst_mem`
- `inst`, in, 8: instruction from `inst_mem`, combinational in `pc`
- `ld_en`, in, 1: preload write enable; honoured only in IDLE
- `ld_addr`, in, 2: preload register index
- `ld_data`, in, DATA_W: preload value
- `rd_addr`, in, 2: debug read index
- `rd_data`, out, DATA_W: combinational read of `reg[rd_addr]`
- `wb_en`, out, 1: write-back strobe, one cycle per instruction
- `wb_addr`, out, 2: write-back destination
- `wb_data`, out, DATA_W: write-back value
- `busy`, out, 1: high in FETCH, DECODE, EXEC and WB
- `done`, out, 1: one-cycle pulse in the DONE state

## Operation
Instruction encoding:
- `inst[7:6]` is the opcode:
  - 00 AND
  - 01 OR
  - 10 XOR
  - 11 ADD, modulo 2**DATA_W, carry discarded
- `inst[5:4]` is the destination register.
- `inst[3:2]` is source A.
- `inst[1:0]` is source B.

State machine states are IDLE, FETCH, DECODE, EXEC, WB and DONE:
- IDLE: `start`=1 moves to FETCH. `pc` is held at 0.
- FETCH: latch `inst` into IR, then move to DECODE.
- DECODE: latch `reg[A]` and `reg[B]` into operand registers, then move to EXEC.
- EXEC: compute the ALU result into RES, then move to WB.
- WB:
  - Write `reg[dest]` <= RES and pulse `wb_en` with `wb_addr`/`wb_data`.
  - If `pc` == PROG_LEN-1: set `pc` <= 0 and move to DONE.
  - Otherwise: set `pc` <= `pc`+1 and move to FETCH.
- DONE: pulse `done`, then move to IDLE.

Rules:
- `start` is ignored outside IDLE. There is no queuing.
- `ld_en` outside IDLE is ignored. In IDLE, a load and `start` in the same cycle are both taken, and the loaded value is visible to the run.
- When dest equals a source, DECODE reads the old value and WB overwrites it.
- `rd_data` reflects a write in the cycle after the write edge.

Reset values (also the result of asserting `rst` at any point, including mid-run):
- state IDLE
- `pc` 0
- IR, operand registers and RES: 0
- all four registers: 0
- `busy`, `done`, `wb_en`: 0
- `wb_addr` 0, `wb_data` 0

A run aborted by reset produces no further write-back.

## Timing
- Instruction latency is 4 cycles, FETCH through WB.
- For the default PROG_LEN=2 with `start` sampled high at edge 0, the sequence is:
  - FETCH during cycle 1
  - first `wb_en` in cycle 4
  - second `wb_en` in cycle 8
  - `done` in cycle 9
  - IDLE from cycle 10
- General case: `done` arrives 4*PROG_LEN+1 cycles after `start`.
- `pc` is stable throughout each instruction and changes only on the WB edge. `inst` must settle within the FETCH cycle.
- `wb_*` outputs are registered and valid only while `wb_en`=1; otherwise they hold their last value.
- A `start` in the DONE cycle is ignored. `start` is accepted again from IDLE.

## Structure
- Shared package `kss_cpu_pkg` holds:
  - the opcode constants OP_AND, OP_OR, OP_XOR, OP_ADD
  - the state enum (6 states)
  - the field-slice positions for dest, A and B
- One sub-module, `reg_file4`, provides 4 x DATA_W storage with:
  - one synchronous write port, muxed between preload and write-back
  - two combinational read ports for DECODE
  - one combinational debug read port
  - synchronous reset to 0
- The ALU is an in-line case statement within `exec_ctrl`.

## Test plan
- Preload r0=0x0F, r1=0x3C. Program 0x24 (AND r2=r1&r0), then 0x74 (OR r3=r1|r0); start. Expect:
  - `wb_en` in cycle 4 with addr 2, data 0x0C
  - `wb_en` in cycle 8 with addr 3, data 0x3F
  - `done` in cycle 9
  - final r2=0x0C, r3=0x3F
- Program 0xF4 (ADD r3=r1+r0), 0x80 (XOR r0=r0^r0) with r0=0xF0, r1=0x20. Expect r3=0x10 (carry dropped) and r0=0x00.
- Program 0xD5 (ADD r1=r1+r1) with r1=0x81. Expect r1=0x02: old value read, dest==src.
- Assert `start` and `ld_en` (r0=0x55) during cycles 2–6 of a run. Expect no restart, r0 unchanged, `done` still in cycle 9. A subsequent IDLE load is accepted.
- Assert `rst` in cycle 6, mid second instruction. Expect, from the next cycle:
  - all registers 0, `pc`=0, `busy`=0
  - no `wb_en`
  - no `done`

  A new `start` then completes normally.
- Start with `ld_en` in the same IDLE cycle (r1=0x3C). Expect the first write-back to use the new r1.
